// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- reusable register between two pipeline stages.
//
// Carries a DATA_W payload and a CTRL_W control field with a valid/ready
// handshake. The 2-bit mode input from the hazard unit can stall or flush
// the stage.
//
// Build option: define PIPE_SKID_EN to add a second (skid) entry.
//   - With the skid entry, ready_o comes from a register (plus the stall gate).
//   - Without it, a single main register is used and ready_o depends
//     combinationally on ready_i.
//
// Handshake: a beat moves on a side only at a rising edge where that
// side's valid and ready are both high. Valid must not depend on ready.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_i        asynchronous, active-high reset
//   mode_i       [0]=flush, [1]=stall (stall wins, so 2'b11 is a stall)
//   valid_i      upstream beat valid
//   ready_o      stage can accept a beat
//   data_i       upstream payload
//   ctrl_i       upstream control field
//   valid_o      output beat valid
//   ready_i      downstream accepts
//   data_o       output payload (keeps its last value while idle)
//   ctrl_o       output control (0 after reset or flush)
//   occupancy_o  number of held entries
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CTRL_W   = 8,
  parameter bit          CLR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        mode_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        occupancy_o
);

  logic w_stall;
  logic w_flush;
  logic w_in_xfer;
  logic w_out_xfer;

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;

  assign w_stall    = mode_i[1];
  assign w_flush    = (mode_i == 2'b01);
  // Stall hides the held beat from downstream without touching any state.
  assign valid_o    = r_main_valid & ~w_stall;
  assign w_out_xfer = valid_o & ready_i;
  assign w_in_xfer  = valid_i & ready_o;
  assign data_o     = r_main_data;
  assign ctrl_o     = r_main_ctrl;

`ifdef PIPE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  // Accept whenever the skid entry is free. A second beat can then land
  // while main is blocked, so ready never has to look at ready_i.
  assign ready_o     = ~r_skid_valid & ~w_stall;
  assign occupancy_o = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
    end else if (!w_stall) begin
      if (w_flush) begin
        // Handshakes this cycle still complete, but the accepted beat is dropped.
        r_main_valid <= 1'b0;
        r_skid_valid <= 1'b0;
        r_main_ctrl  <= '0;
        if (CLR_DATA) r_main_data <= '0;
      end else if (w_out_xfer) begin
        if (r_skid_valid) begin
          // ready_o is low while skid is full, so no input can arrive here.
          r_main_data  <= r_skid_data;
          r_main_ctrl  <= r_skid_ctrl;
          r_skid_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_main_data <= data_i;
          r_main_ctrl <= ctrl_i;
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_in_xfer) begin
        if (!r_main_valid) begin
          r_main_valid <= 1'b1;
          r_main_data  <= data_i;
          r_main_ctrl  <= ctrl_i;
        end else begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= data_i;
          r_skid_ctrl  <= ctrl_i;
        end
      end
    end
  end
`else
  // Single register: accept when empty, or when the held beat leaves this cycle.
  assign ready_o     = (~r_main_valid | ready_i) & ~w_stall;
  assign occupancy_o = {1'b0, r_main_valid};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
    end else if (!w_stall) begin
      if (w_flush) begin
        r_main_valid <= 1'b0;
        r_main_ctrl  <= '0;
        if (CLR_DATA) r_main_data <= '0;
      end else if (w_in_xfer) begin
        r_main_valid <= 1'b1;
        r_main_data  <= data_i;
        r_main_ctrl  <= ctrl_i;
      end else if (w_out_xfer) begin
        r_main_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg.
// A FIFO of accepted beats is kept as the reference. Its front is the expected
// output beat, and its size is the expected occupancy.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int W      = DATA_W + CTRL_W;
  localparam bit CLR    = 1'b1;

  logic              clk_i;
  logic              rst_i;
  logic [1:0]        mode_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [1:0]        occupancy_o;

  logic [W-1:0]      exp_q[$];
  logic [DATA_W-1:0] last_data;
  logic [CTRL_W-1:0] last_ctrl;
  int n_checks;
  int n_errors;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(CLR)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .ctrl_i(ctrl_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .ctrl_o(ctrl_o),
    .occupancy_o(occupancy_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic v, input logic r,
                       input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    mode_i  = m;
    valid_i = v;
    ready_i = r;
    data_i  = d;
    ctrl_i  = c;
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_data = '0;
    last_ctrl = '0;
  endtask

  // Called just after a falling edge with inputs applied. It checks the
  // outputs, advances the reference across the next rising edge, and then
  // returns on the following falling edge.
  task automatic step();
    logic exp_valid;
    logic exp_ready;
    logic in_x;
    logic out_x;
    logic [W-1:0] beat;
    #1;
    exp_valid = (exp_q.size() > 0) && !mode_i[1];
`ifdef PIPE_SKID_EN
    exp_ready = (exp_q.size() < 2) && !mode_i[1];
`else
    exp_ready = ((exp_q.size() == 0) || ready_i) && !mode_i[1];
`endif
    check_eq("valid_o", W'(valid_o), W'(exp_valid));
    check_eq("ready_o", W'(ready_o), W'(exp_ready));
    check_eq("data_o", W'(data_o), W'(last_data));
    check_eq("ctrl_o", W'(ctrl_o), W'(last_ctrl));
    check_eq("occupancy_o", W'(occupancy_o), W'(exp_q.size()));
    in_x  = valid_i && exp_ready;
    out_x = exp_valid && ready_i;
    if (!mode_i[1]) begin
      if (out_x) begin
        beat = exp_q.pop_front();
        check_eq("out_beat", {ctrl_o, data_o}, beat);
      end
      if (mode_i[0]) begin
        exp_q.delete();
        last_ctrl = '0;
        if (CLR) last_data = '0;
      end else begin
        if (in_x) exp_q.push_back({ctrl_i, data_i});
        if (exp_q.size() > 0) {last_ctrl, last_data} = exp_q[0];
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(2'b00, 1'b0, 1'b0, '0, '0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] pat[3];
    int max_occ;
    n_checks = 0;
    n_errors = 0;
`ifdef PIPE_SKID_EN
    max_occ = 2;
`else
    max_occ = 1;
`endif
    pat[0] = 32'h11;
    pat[1] = 32'h22;
    pat[2] = 32'h33;

    // 1: reset values, then back-to-back stream with 1-cycle latency
    do_reset();
    check_eq("rst_valid", W'(valid_o), W'(1'b0));
    check_eq("rst_ready", W'(ready_o), W'(1'b1));
    check_eq("rst_occ", W'(occupancy_o), W'(0));
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 1'b1, 1'b1, pat[i], 8'(i + 1));
      step();
      check_eq("t1_latency", W'(data_o), W'(pat[i]));
    end
    drive(2'b00, 1'b0, 1'b1, '0, '0);
    step();
    step();

    // 2: fill the stage with ready_i low, then drain in order
    drive(2'b00, 1'b1, 1'b0, 32'h0A, 8'h1);
    step();
    drive(2'b00, 1'b1, 1'b0, 32'h0B, 8'h2);
    step();
    drive(2'b00, 1'b0, 1'b0, '0, '0);
    #1;
    check_eq("t2_full_occ", W'(occupancy_o), W'(max_occ));
    check_eq("t2_full_ready", W'(ready_o), W'(1'b0));
    step();
    drive(2'b00, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 3; i++) step();

    // 3: stall holds the state and hides both valids
    drive(2'b00, 1'b1, 1'b0, 32'h44, 8'h3);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b1, 1'b1, 32'h99, 8'h9);
      step();
      check_eq("t3_stall_data", W'(data_o), W'(32'h44));
      check_eq("t3_stall_occ", W'(occupancy_o), W'(1));
      check_eq("t3_stall_valid", W'(valid_o), W'(1'b0));
    end
    drive(2'b00, 1'b0, 1'b1, '0, '0);
    step();
    step();

    // 4: flush from a full stage drops everything, including the new beat
    drive(2'b00, 1'b1, 1'b0, 32'h0C, 8'h4);
    step();
    drive(2'b00, 1'b1, 1'b0, 32'h0D, 8'h5);
    step();
    drive(2'b01, 1'b1, 1'b0, 32'h55, 8'hFF);
    step();
    drive(2'b00, 1'b0, 1'b1, '0, '0);
    #1;
    check_eq("t4_flush_valid", W'(valid_o), W'(1'b0));
    check_eq("t4_flush_ctrl", W'(ctrl_o), W'(0));
    check_eq("t4_flush_data", W'(data_o), W'(0));
    check_eq("t4_flush_occ", W'(occupancy_o), W'(0));
    step();
    step();

    // 5: mode 2'b11 acts as a stall
    drive(2'b00, 1'b1, 1'b0, 32'h66, 8'h6);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 1'b1, 1'b1, 32'h77, 8'h7);
      step();
      check_eq("t5_both_data", W'(data_o), W'(32'h66));
      check_eq("t5_both_occ", W'(occupancy_o), W'(1));
    end
    drive(2'b00, 1'b0, 1'b1, '0, '0);
    step();
    step();

    // 6: asynchronous reset in the middle of a stream
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, 1'b1, 1'b0, 32'hA0 + 32'(i), 8'h8);
      step();
    end
    rst_i = 1'b1;
    #2;
    check_eq("t6_async_valid", W'(valid_o), W'(1'b0));
    check_eq("t6_async_occ", W'(occupancy_o), W'(0));
    check_eq("t6_async_ctrl", W'(ctrl_o), W'(0));
    model_reset();
    rst_i = 1'b0;
    drive(2'b00, 1'b1, 1'b1, 32'h78, 8'h2A);
    step();
    drive(2'b00, 1'b0, 1'b1, '0, '0);
    #1;
    check_eq("t6_first_beat", W'(data_o), W'(32'h78));
    check_eq("t6_first_valid", W'(valid_o), W'(1'b1));
    step();

    // random traffic with occasional stall and flush
    for (int i = 0; i < 300; i++) begin
      int m;
      logic [1:0] mv;
      m  = $urandom_range(0, 9);
      mv = (m < 7) ? 2'b00 : (m == 7) ? 2'b01 : (m == 8) ? 2'b10 : 2'b11;
      drive(mv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom), 8'($urandom_range(0, 255)));
      step();
    end
    drive(2'b00, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 4; i++) step();
    check_eq("drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
